// File: rtl/flash_pkg.sv
// Shared state encodings and default timing for the flash burst arbiter.
package flash_pkg;

  localparam int TIMEOUT_DEF = 64;
  localparam int DRAIN_DEF   = 32;

  typedef enum logic [2:0] {
    ST_DRAIN   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_DELIVER = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_burst_arbiter.sv
// Two-requester round-robin arbiter that turns burst requests into single-byte
// flash reads, one outstanding transaction at a time, with requester backpressure.
//
// state      | meaning
// DRAIN      | post-reset hold-off, fl_ready ignored
// IDLE       | sample req, pick winner
// ISSUE      | one-cycle fl_read strobe
// WAIT       | wait for fl_ready or timeout
// DELIVER    | hold byte until granted requester acks
// DONE       | pulse done, release grant
module flash_burst_arbiter
  import flash_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int DRAIN   = DRAIN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [7:0]  len0,
  input  logic [7:0]  len1,
  output logic [1:0]  gnt,
  output logic [1:0]  rd_valid,
  output logic [7:0]  rd_data,
  input  logic [1:0]  rd_ack,
  output logic [1:0]  done,
  output logic        err,
  output logic        fl_read,
  output logic [23:0] fl_addr,
  input  logic        fl_ready,
  input  logic [7:0]  fl_data
);

  localparam int CNT_W = $clog2(max_int(TIMEOUT, DRAIN) + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN - 1);
  // WAIT exits one cycle early so err lands exactly TIMEOUT cycles after fl_read.
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT - 2);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             cur_g;
  logic             pick;
  logic [23:0]      cur_addr;
  logic [8:0]       remaining;
  logic             ack_hit;
  logic             last_byte;
  logic             wait_expired;

  assign fl_read = (state == ST_ISSUE);
  assign fl_addr = cur_addr;

  always_comb begin
    pick = ~last_gnt;
    if (req == 2'b01)      pick = 1'b0;
    else if (req == 2'b10) pick = 1'b1;
  end

  always_comb begin
    ack_hit      = (state == ST_DELIVER) && rd_ack[cur_g];
    last_byte    = (remaining == 9'd1);
    wait_expired = (cnt == WAIT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_DRAIN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_DRAIN:   if (cnt == DRAIN_LAST) state_nxt = ST_IDLE;
      ST_IDLE:    if (req != 2'b00) state_nxt = ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (fl_ready)          state_nxt = ST_DELIVER;
        else if (wait_expired) state_nxt = ST_DONE;
      end
      ST_DELIVER: if (ack_hit) state_nxt = last_byte ? ST_DONE : ST_ISSUE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      last_gnt  <= 1'b1;
      cur_g     <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      gnt       <= '0;
      rd_valid  <= '0;
      rd_data   <= '0;
      done      <= '0;
      err       <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      unique case (state)
        ST_DRAIN: cnt <= (cnt == DRAIN_LAST) ? '0 : cnt + 1'b1;
        ST_IDLE: begin
          if (req != 2'b00) begin
            cur_g <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            // A zero length field means a full 256-byte burst.
            if (pick) begin
              cur_addr  <= addr1;
              remaining <= {(len1 == 8'd0), len1};
            end else begin
              cur_addr  <= addr0;
              remaining <= {(len0 == 8'd0), len0};
            end
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (fl_ready) begin
            rd_data  <= fl_data;
            rd_valid <= gnt;
          end else if (wait_expired) begin
            err  <= 1'b1;
            done <= gnt;
            cnt  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DELIVER: begin
          if (ack_hit) begin
            rd_valid  <= '0;
            cur_addr  <= cur_addr + 24'd1;
            remaining <= remaining - 9'd1;
            if (last_byte) done <= gnt;
          end
        end
        ST_DONE: begin
          gnt      <= '0;
          last_gnt <= cur_g;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_burst_arbiter.sv
// Directed bench for flash_burst_arbiter with a latency-programmable flash reader model.
module tb_flash_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [23:0] addr0, addr1;
  logic [7:0]  len0, len1;
  logic [1:0]  gnt, rd_valid, rd_ack, done;
  logic [7:0]  rd_data;
  logic        err, fl_read, fl_ready;
  logic [23:0] fl_addr;
  logic [7:0]  fl_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          rdr_en = 1'b1;
  int          lat = 2;
  int          strobes = 0, done0 = 0, done1 = 0, errs = 0, last_read_cyc = 0;
  logic [23:0] addr_q[$];
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic [23:0] paddr = '0;

  flash_burst_arbiter #(.TIMEOUT(64), .DRAIN(32)) dut (
    .clk(clk), .rst(rst), .req(req), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ack(rd_ack), .done(done), .err(err), .fl_read(fl_read), .fl_addr(fl_addr),
    .fl_ready(fl_ready), .fl_data(fl_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mdl(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Reader model plus event monitor; everything is sampled on the falling edge.
  initial begin
    fl_ready = 1'b0;
    fl_data  = 8'h00;
    forever begin
      @(negedge clk);
      fl_ready = 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          fl_ready = 1'b1;
          fl_data  = mdl(paddr);
          pend     = 1'b0;
        end else begin
          pcnt--;
        end
      end
      if (fl_read === 1'b1) begin
        strobes++;
        addr_q.push_back(fl_addr);
        last_read_cyc = cyc;
        if (rdr_en) begin
          pend  = 1'b1;
          pcnt  = lat - 1;
          paddr = fl_addr;
        end
      end
      if (done[0] === 1'b1) done0++;
      if (done[1] === 1'b1) done1++;
      if (err === 1'b1) errs++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(output int rel);
    rst = 1'b1;
    rd_ack = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rel = cyc;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (gnt != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rd_valid[idx] === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done != 2'b00) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic ack_byte(input int idx);
    rd_ack = (idx == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    rd_ack = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL reset_rd_valid: got %b expected 00", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (fl_read !== 1'b0) begin errors++; $display("FAIL reset_fl_read: got %b expected 0", fl_read); end
    checks++; if (fl_addr !== 24'h0) begin errors++; $display("FAIL reset_fl_addr: got %h expected 000000", fl_addr); end
  endtask

  task automatic test_single_burst();
    int r, fr, s, q0, d0, e0;
    bit ok;
    rdr_en = 1'b1; lat = 28;
    addr0 = 24'h400000; len0 = 8'd3;
    do_reset(r);
    s = strobes; q0 = addr_q.size(); d0 = done0; e0 = errs;
    req = 2'b01;
    wait_gnt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_gnt: got no grant expected 01"); end
    req = 2'b00;
    fr = -1;
    for (int i = 0; i < 200; i++) begin
      if (fl_read === 1'b1) begin fr = cyc; break; end
      @(negedge clk);
    end
    checks++; if (fr - r <= 32) begin errors++; $display("FAIL single_drain: got first fl_read %0d cycles after reset expected >32", fr - r); end
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, ok);
      checks++;
      if (!ok || rd_data !== mdl(24'(32'h400000 + i))) begin
        errors++;
        $display("FAIL single_byte%0d: got valid=%b data=%h expected %h", i, ok, rd_data, mdl(24'(32'h400000 + i)));
      end
      ack_byte(0);
    end
    wait_done(ok);
    checks++; if (!ok || done !== 2'b01) begin errors++; $display("FAIL single_done: got %b expected 01", done); end
    @(negedge clk);
    checks++; if (strobes - s != 3) begin errors++; $display("FAIL single_strobes: got %0d expected 3", strobes - s); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_q.size() <= q0 + i || addr_q[q0 + i] !== 24'(32'h400000 + i)) begin
        errors++;
        $display("FAIL single_addr%0d: got %h expected %h", i, (addr_q.size() > q0 + i) ? addr_q[q0 + i] : 24'hxxxxxx, 24'(32'h400000 + i));
      end
    end
    checks++; if (done0 - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done0 - d0); end
    checks++; if (errs != e0) begin errors++; $display("FAIL single_err_count: got %0d expected 0", errs - e0); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_release: got %b expected 00", gnt); end
  endtask

  task automatic test_round_robin();
    int r, g;
    bit ok;
    logic [1:0] exp_oh;
    logic [23:0] a;
    lat = 2;
    addr0 = 24'h000010; addr1 = 24'h000020; len0 = 8'd1; len1 = 8'd1;
    do_reset(r);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = k % 2;
      exp_oh = (g == 1) ? 2'b10 : 2'b01;
      a = (g == 1) ? 24'h000020 : 24'h000010;
      wait_gnt(ok);
      checks++; if (!ok || gnt !== exp_oh) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", k, gnt, exp_oh); end
      if (k == 3) req = 2'b00;
      wait_valid(g, ok);
      checks++; if (!ok || rd_data !== mdl(a)) begin errors++; $display("FAIL rr_data%0d: got %h expected %h", k, rd_data, mdl(a)); end
      ack_byte(g);
      wait_done(ok);
      checks++; if (!ok || done !== exp_oh) begin errors++; $display("FAIL rr_done%0d: got %b expected %b", k, done, exp_oh); end
      @(negedge clk);
    end
  endtask

  task automatic test_addr_wrap();
    int s, q0;
    bit ok;
    lat = 2;
    addr1 = 24'hFFFFFF; len1 = 8'd2;
    s = strobes; q0 = addr_q.size();
    req = 2'b10;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 2'b10) begin errors++; $display("FAIL wrap_gnt: got %b expected 10", gnt); end
    req = 2'b00;
    wait_valid(1, ok);
    checks++; if (!ok || rd_data !== mdl(24'hFFFFFF)) begin errors++; $display("FAIL wrap_byte0: got %h expected %h", rd_data, mdl(24'hFFFFFF)); end
    ack_byte(1);
    wait_valid(1, ok);
    checks++; if (!ok || rd_data !== mdl(24'h000000)) begin errors++; $display("FAIL wrap_byte1: got %h expected %h", rd_data, mdl(24'h000000)); end
    ack_byte(1);
    wait_done(ok);
    checks++; if (!ok || done !== 2'b10) begin errors++; $display("FAIL wrap_done: got %b expected 10", done); end
    @(negedge clk);
    checks++; if (strobes - s != 2) begin errors++; $display("FAIL wrap_strobes: got %0d expected 2", strobes - s); end
    checks++; if (addr_q.size() < q0 + 2 || addr_q[q0] !== 24'hFFFFFF || addr_q[q0 + 1] !== 24'h000000) begin
      errors++;
      $display("FAIL wrap_addr: got %0d strobes logged, expected FFFFFF then 000000", addr_q.size() - q0);
    end
  endtask

  task automatic test_len256();
    int s, d0, nbytes, bad;
    bit ok;
    lat = 1;
    addr0 = 24'h123400; len0 = 8'd0;
    s = strobes; d0 = done0; nbytes = 0; bad = 0;
    req = 2'b01;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 2'b01) begin errors++; $display("FAIL len256_gnt: got %b expected 01", gnt); end
    req = 2'b00;
    for (int i = 0; i < 256; i++) begin
      wait_valid(0, ok);
      if (!ok) break;
      if (rd_data !== mdl(24'(32'h123400 + i))) bad++;
      nbytes++;
      ack_byte(0);
    end
    wait_done(ok);
    checks++; if (!ok || done !== 2'b01) begin errors++; $display("FAIL len256_done: got %b expected 01", done); end
    @(negedge clk);
    checks++; if (nbytes != 256) begin errors++; $display("FAIL len256_bytes: got %0d expected 256", nbytes); end
    checks++; if (bad != 0) begin errors++; $display("FAIL len256_data: got %0d bad bytes expected 0", bad); end
    checks++; if (strobes - s != 256) begin errors++; $display("FAIL len256_strobes: got %0d expected 256", strobes - s); end
    checks++; if (done0 - d0 != 1) begin errors++; $display("FAIL len256_done_count: got %0d expected 1", done0 - d0); end
  endtask

  task automatic test_timeout();
    int s, dc;
    bit ok;
    rdr_en = 1'b0;
    addr0 = 24'h000100; len0 = 8'd2;
    s = strobes;
    req = 2'b01;
    wait_gnt(ok);
    checks++; if (!ok || gnt !== 2'b01) begin errors++; $display("FAIL to_gnt: got %b expected 01", gnt); end
    req = 2'b00;
    wait_done(ok);
    dc = cyc;
    checks++; if (!ok || done !== 2'b01) begin errors++; $display("FAIL to_done: got %b expected 01", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1 with done", err); end
    @(negedge clk);
    checks++; if (dc - last_read_cyc != 64) begin errors++; $display("FAIL to_latency: got %0d expected 64", dc - last_read_cyc); end
    checks++; if (strobes - s != 1) begin errors++; $display("FAIL to_strobes: got %0d expected 1", strobes - s); end
    checks++; if (gnt !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL to_release: got gnt=%b err=%b expected 00/0", gnt, err); end
    rdr_en = 1'b1; lat = 2; len0 = 8'd1;
    req = 2'b01;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL to_regrant: got %b expected 01", gnt); end
    req = 2'b00;
    wait_valid(0, ok);
    checks++; if (!ok || rd_data !== mdl(24'h000100)) begin errors++; $display("FAIL to_next_byte: got %h expected %h", rd_data, mdl(24'h000100)); end
    ack_byte(0);
    wait_done(ok);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int vbad, dbad, rbad;
    bit ok;
    lat = 3;
    addr0 = 24'h00AB00; len0 = 8'd2;
    vbad = 0; dbad = 0; rbad = 0;
    req = 2'b01;
    wait_gnt(ok);
    req = 2'b00;
    wait_valid(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_first_valid: got no rd_valid expected 01"); end
    for (int i = 0; i < 100; i++) begin
      rd_ack = (i >= 40 && i < 60) ? 2'b10 : 2'b00;
      @(negedge clk);
      if (rd_valid !== 2'b01) vbad++;
      if (rd_data !== mdl(24'h00AB00)) dbad++;
      if (fl_read !== 1'b0) rbad++;
    end
    rd_ack = 2'b00;
    checks++; if (vbad != 0) begin errors++; $display("FAIL bp_valid_hold: got %0d bad cycles expected 0", vbad); end
    checks++; if (dbad != 0) begin errors++; $display("FAIL bp_data_hold: got %0d bad cycles expected 0", dbad); end
    checks++; if (rbad != 0) begin errors++; $display("FAIL bp_no_read: got %0d fl_read cycles expected 0", rbad); end
    ack_byte(0);
    wait_valid(0, ok);
    checks++; if (!ok || rd_data !== mdl(24'h00AB01)) begin errors++; $display("FAIL bp_second_byte: got %h expected %h", rd_data, mdl(24'h00AB01)); end
    ack_byte(0);
    wait_done(ok);
    checks++; if (!ok || done !== 2'b01) begin errors++; $display("FAIL bp_done: got %b expected 01", done); end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wait();
    int r, fr, d0, e0, vbad, bad;
    bit ok;
    lat = 20;
    addr0 = 24'h0F0000; len0 = 8'd3;
    req = 2'b01;
    wait_gnt(ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (fl_read === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL rw_first_read: got no fl_read expected one"); end
    repeat (5) @(negedge clk);
    d0 = done0; e0 = errs;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt !== 2'b00 || rd_valid !== 2'b00 || rd_data !== 8'h00 || fl_read !== 1'b0 ||
        fl_addr !== 24'h0 || done !== 2'b00 || err !== 1'b0) begin
      errors++;
      $display("FAIL rw_outputs: got gnt=%b vld=%b data=%h rd=%b addr=%h done=%b err=%b expected all 0",
               gnt, rd_valid, rd_data, fl_read, fl_addr, done, err);
    end
    rst = 1'b0;
    r = cyc;
    fr = -1; vbad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_valid !== 2'b00) vbad++;
      if (fl_read === 1'b1) begin fr = cyc; break; end
    end
    checks++; if (fr < 0 || fr - r <= 32) begin errors++; $display("FAIL rw_drain: got first fl_read %0d cycles after reset expected >32", fr - r); end
    checks++; if (vbad != 0) begin errors++; $display("FAIL rw_late_ready: got %0d rd_valid cycles expected 0", vbad); end
    checks++; if (done0 != d0 || errs != e0) begin errors++; $display("FAIL rw_no_pulse: got done=%0d err=%0d expected 0/0", done0 - d0, errs - e0); end
    req = 2'b00;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(0, ok);
      if (!ok || rd_data !== mdl(24'(32'h0F0000 + i))) bad++;
      ack_byte(0);
    end
    wait_done(ok);
    checks++; if (bad != 0 || !ok) begin errors++; $display("FAIL rw_rerun: got %0d bad bytes done_seen=%b expected 0/1", bad, ok); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; rd_ack = 2'b00;
    addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_addr_wrap();
    test_len256();
    test_timeout();
    test_backpressure();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_burst_arbiter.md
FLASH_BURST_ARBITER -- requirements
Module: flash_burst_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, giving the maximum cycles to wait for fl_ready per byte.
REQ-002 SHALL have parameter DRAIN, default 32, giving the post-reset hold-off cycles before the first flash read.
REQ-003 SHALL have clk  input  1  system clock (72 MHz domain); all logic is on its rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have req  input  2  per-requester burst request, level, bit i = requester i.
REQ-006 SHALL have addr0, addr1  input  24  burst start address per requester.
REQ-007 SHALL have len0, len1  input  8  burst length per requester; 0 means 256 bytes.
REQ-008 SHALL have gnt  output  2  one-hot grant, held for the whole burst.
REQ-009 SHALL have rd_valid  output  2  byte available for requester i, held until acknowledged.
REQ-010 SHALL have rd_data  output  8  shared byte bus, valid while any rd_valid bit is set.
REQ-011 SHALL have rd_ack  input  2  requester i accepts the byte; only sampled while rd_valid[i]=1.
REQ-012 SHALL have done  output  2  one-cycle pulse at burst end for requester i.
REQ-013 SHALL have err  output  1  one-cycle pulse, coincident with done, when a burst aborts on timeout.
REQ-014 SHALL have fl_read  output  1  one-cycle read strobe to the flash reader.
REQ-015 SHALL have fl_addr  output  24  byte address, stable from fl_read until fl_ready.
REQ-016 SHALL have fl_ready  input  1  one-cycle pulse from the reader with the byte on fl_data.
REQ-017 SHALL have fl_data  input  8  byte returned by the reader.

Function
REQ-018 SHALL implement states DRAIN, IDLE, ISSUE, WAIT, DELIVER, DONE.
REQ-019 DRAIN SHALL count DRAIN cycles, ignore fl_ready, then go to IDLE.
REQ-020 IDLE SHALL sample req each cycle.
- One requester set: grant it.
- Both set: grant the requester not granted last (round-robin).
- After reset, requester 0 wins the first tie.
REQ-021 On grant, SHALL latch the start address into cur_addr and the length into remaining (0 loaded as 256, 9-bit), set gnt next cycle, and go to ISSUE.
REQ-022 ISSUE SHALL assert fl_read for exactly one cycle with fl_addr=cur_addr, clear the timeout counter, and go to WAIT.
REQ-023 WAIT SHALL, on fl_ready, register fl_data into rd_data, set rd_valid[g] next cycle, and go to DELIVER.
REQ-024 WAIT SHALL, after TIMEOUT cycles without fl_ready, pulse err and go to DONE.
REQ-025 DELIVER SHALL hold rd_valid[g] and rd_data until rd_ack[g]=1; this is the backpressure point, with no timeout.
REQ-026 On the ack cycle, DELIVER SHALL clear rd_valid, set cur_addr=cur_addr+1 (24-bit wrap, 0xFFFFFF->0x000000) and remaining=remaining-1.
REQ-027 After the ack, DELIVER SHALL go to DONE if the new remaining is 0, else to ISSUE.
REQ-028 Minimum per-byte latency SHALL be: ISSUE 1 cycle, reader latency, rd_valid 1 cycle after fl_ready, ISSUE 1 cycle after ack.
REQ-029 DONE SHALL pulse done[g], drop gnt, record g as last-granted, and return to IDLE, where a new grant is possible next cycle.
REQ-030 req changes during a burst SHALL be ignored; deasserting req does not abort a burst.
REQ-031 rd_ack on the non-granted bit, or outside DELIVER, SHALL be ignored.
REQ-032 fl_ready outside WAIT SHALL be ignored.
REQ-033 fl_read SHALL never be asserted outside ISSUE, and at most one flash transaction SHALL be outstanding.

Reset
REQ-034 On rst, all outputs SHALL be 0 on the next edge: gnt, rd_valid, rd_data, done, err, fl_read, fl_addr.
REQ-035 On rst, state SHALL be DRAIN, last-granted SHALL be 1, and counters SHALL be cleared.
REQ-036 Reset mid-burst SHALL abort with no done or err pulse, and SHALL NOT issue fl_read before DRAIN expires.

Structure
REQ-037 State encodings and the default TIMEOUT/DRAIN values SHALL live in shared package flash_pkg.
REQ-038 The design SHALL be a single module with no sub-modules; the round-robin picker is inline logic.

Verification
REQ-039 Reset, then req=01, addr0=0x400000, len0=3, reader model with 28-cycle latency, ack immediately -> fl_addr 0x400000/0x400001/0x400002 on 3 fl_read strobes; 3 bytes delivered in order; done[0] pulses once; no fl_read within 32 cycles of reset.
REQ-040 req=11 held, both len=1 -> grants alternate 0,1,0,1; done alternates to match.
REQ-041 addr1=0xFFFFFF, len1=2 -> fl_addr 0xFFFFFF then 0x000000.
REQ-042 len0=0 -> exactly 256 strobes and bytes, then done[0].
REQ-043 Reader never returns fl_ready -> err and done[0] pulse together exactly TIMEOUT cycles after fl_read; arbiter back in IDLE.
REQ-044 rd_ack withheld 100 cycles -> rd_valid and rd_data stable, no fl_read.
REQ-045 rst asserted in WAIT -> outputs 0 next cycle; a late fl_ready is ignored; no done or err pulse.
